// File: rtl/bnn_neuron_acc.sv
// Binary neural-network neuron: XNOR-popcount of activation words against a 16x32
// weight memory, then threshold compare. Define BNN_NEURON_STALL_CNT_EN to add the stall_cycles output.
module bnn_neuron_acc (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [4:0]  cfg_num_words,
  input  logic [9:0]  cfg_threshold,
  input  logic        w_we,
  input  logic [3:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        start,
  input  logic        x_valid,
  input  logic [31:0] x_data,
  output logic        x_ready,
  output logic        busy,
  output logic        done,
  output logic        result,
  output logic [9:0]  popcount
`ifdef BNN_NEURON_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  // Handshake: a word transfers on a rising edge where x_valid & x_ready; x_ready
  // depends on state only, so the producer may hold x_valid without a combinational loop.

  state_t      state_q, state_d;
  logic [4:0]  num_q, num_d;
  logic [9:0]  thr_q, thr_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  acc_q, acc_d;
  logic [9:0]  popcount_q, popcount_d;
  logic        result_q, result_d;
  logic        done_q, done_d;
  logic [31:0] w_mem_q [16];
  logic [4:0]  num_clamped;
  logic [5:0]  word_pc;
`ifdef BNN_NEURON_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
`endif

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  assign num_clamped = (cfg_num_words > 5'd16) ? 5'd16 : cfg_num_words;
  // Combinational read sees the pre-edge contents, so same-cycle writes are read-before-write.
  assign word_pc     = popcnt32(~(x_data ^ w_mem_q[idx_q]));

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    thr_d      = thr_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    popcount_d = popcount_q;
    result_d   = result_q;
    done_d     = 1'b0;
`ifdef BNN_NEURON_STALL_CNT_EN
    stall_d    = stall_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_clamped;
          thr_d   = cfg_threshold;
          acc_d   = '0;
          idx_d   = '0;
          state_d = (num_clamped == 5'd0) ? S_FINISH : S_RUN;
`ifdef BNN_NEURON_STALL_CNT_EN
          stall_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (x_valid) begin
          acc_d = acc_q + {4'd0, word_pc};
          idx_d = idx_q + 4'd1;
          if ({1'b0, idx_q} == num_q - 5'd1) state_d = S_FINISH;
        end
`ifdef BNN_NEURON_STALL_CNT_EN
        else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end
      S_FINISH: begin
        popcount_d = acc_q;
        result_d   = (acc_q >= thr_q);
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      thr_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      popcount_q <= '0;
      result_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef BNN_NEURON_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      thr_q      <= thr_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      popcount_q <= popcount_d;
      result_q   <= result_d;
      done_q     <= done_d;
`ifdef BNN_NEURON_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // Weights survive reset; reset only blocks a write issued in the same cycle.
  always_ff @(posedge ACLK) begin
    if (w_we && !ARESET) w_mem_q[w_addr] <= w_data;
  end

  assign x_ready  = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign popcount = popcount_q;
`ifdef BNN_NEURON_STALL_CNT_EN
  assign stall_cycles = stall_q;
`endif

endmodule
